// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite responder backed by a word-organised memory, with fixed wait states and little-endian byte lanes.
// Define AHB_SLV_ERR_EN to enable range/size/alignment checking with a two-cycle ERROR response.
module ahb_lite_slave_mem #(
   parameter int unsigned MEM_WORDS   = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [1:0]  HTRANS,
   input  logic        HMASTLOCK,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [3:0] WAIT_CNT_INIT = 4'(WAIT_STATES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
`ifdef AHB_SLV_ERR_EN
   localparam logic [1:0] ST_ERR1 = 2'd2;
   localparam logic [1:0] ST_ERR2 = 2'd3;
`endif

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [3:0]    wait_cnt;
   logic [3:0]    wait_cnt_nxt;
   logic [AW-1:0] word_q;
   logic [1:0]    lane_q;
   logic          write_q;
   logic [2:0]    size_q;
   logic          in_range_q;

   logic [31:0]   offset;
   logic          in_range;
   logic          accept;
   logic          ready_int;
   logic          resp_int;
   logic          commit;
   logic [3:0]    byte_en;
   logic [31:0]   mem [MEM_WORDS];

   logic          unused_ok;
   assign unused_ok = &{1'b0, HBURST, HPROT, HMASTLOCK, HTRANS[0]};

   assign offset   = HADDR - BASE_ADDR;
   assign in_range = (offset[31:AW+2] == '0);
   assign accept   = HSEL & HREADY & HTRANS[1] & ready_int;

`ifdef AHB_SLV_ERR_EN
   logic bad_access;

   always_comb begin
      bad_access = !in_range || (HSIZE > 3'd2);
      if (HSIZE == 3'd1 && offset[0]) begin
         bad_access = 1'b1;
      end
      if (HSIZE == 3'd2 && offset[1:0] != 2'b00) begin
         bad_access = 1'b1;
      end
   end
`endif

   // A data phase completes whenever this slave is ready; that same edge may accept the next address phase.
   always_comb begin
      ready_int = 1'b1;
      resp_int  = 1'b0;
      case (state)
         ST_DATA: ready_int = (wait_cnt == 4'd0);
`ifdef AHB_SLV_ERR_EN
         ST_ERR1: begin
            ready_int = 1'b0;
            resp_int  = 1'b1;
         end
         ST_ERR2: resp_int = 1'b1;
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      if (ready_int) begin
         state_nxt = ST_IDLE;
         if (accept) begin
`ifdef AHB_SLV_ERR_EN
            state_nxt = bad_access ? ST_ERR1 : ST_DATA;
`else
            state_nxt = ST_DATA;
`endif
            wait_cnt_nxt = WAIT_CNT_INIT;
         end
      end else if (state == ST_DATA) begin
         wait_cnt_nxt = wait_cnt - 4'd1;
      end
`ifdef AHB_SLV_ERR_EN
      else if (state == ST_ERR1) begin
         state_nxt = ST_ERR2;
      end
`endif
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= ST_IDLE;
         wait_cnt   <= 4'd0;
         word_q     <= '0;
         lane_q     <= 2'b00;
         write_q    <= 1'b0;
         size_q     <= 3'd0;
         in_range_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (accept) begin
            word_q     <= offset[AW+1:2];
            lane_q     <= offset[1:0];
            write_q    <= HWRITE;
            size_q     <= HSIZE;
            in_range_q <= in_range;
         end
      end
   end

   // Out-of-range writes are dropped here, which also covers the build without error responses.
   assign commit = (state == ST_DATA) && ready_int && write_q && in_range_q;

   always_comb begin
      byte_en = 4'b1111;
      case (size_q)
         3'd0:    byte_en = 4'b0001 << lane_q;
         3'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[word_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

   assign HRDATA    = (state == ST_DATA && ready_int && !write_q && in_range_q) ? mem[word_q] : 32'h0;
   assign HREADYOUT = ready_int;
   assign HRESP     = resp_int;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench for ahb_lite_slave_mem: two instances (no wait states at base 0, three wait states at base 0x100)
// driven by a pipelined AHB-Lite master loop and compared against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_ahb_lite_slave_mem;

   localparam int          MEM_WORDS = 16;
   localparam int          MEM_BYTES = 4 * MEM_WORDS;
   localparam logic [31:0] BASE0     = 32'h0000_0000;
   localparam logic [31:0] BASE1     = 32'h0000_0100;
   localparam int          WS0       = 0;
   localparam int          WS1       = 3;
   localparam logic [1:0]  T_IDLE    = 2'b00;
   localparam logic [1:0]  T_BUSY    = 2'b01;
   localparam logic [1:0]  T_NONSEQ  = 2'b10;
   localparam logic [1:0]  T_SEQ     = 2'b11;

   typedef struct packed {
      logic        sel;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
   } beat_t;

   logic        HCLK = 1'b0;
   logic        hresetn   [2];
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [2:0]  hburst    [2];
   logic [3:0]  hprot     [2];
   logic [1:0]  htrans    [2];
   logic        hmastlock [2];
   logic        hready    [2];
   logic [31:0] hwdata    [2];
   logic [31:0] hrdata    [2];
   logic        hreadyout [2];
   logic        hresp     [2];

   int          testsRun;
   int          testsFailed;
   logic [31:0] lastRead;
   int          lastWait;
   logic [7:0]  mbytes [2][MEM_BYTES];
   beat_t       beats[$];

   always #5 HCLK = ~HCLK;

   assign hready[0] = hreadyout[0];
   assign hready[1] = hreadyout[1];

   ahb_lite_slave_mem #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) dut0 (
      .HCLK(HCLK), .HRESETn(hresetn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
      .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]), .HTRANS(htrans[0]),
      .HMASTLOCK(hmastlock[0]), .HREADY(hready[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]),
      .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
   );

   ahb_lite_slave_mem #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) dut1 (
      .HCLK(HCLK), .HRESETn(hresetn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
      .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]), .HTRANS(htrans[1]),
      .HMASTLOCK(hmastlock[1]), .HREADY(hready[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]),
      .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic int wsOf(input int inst);
      return (inst == 0) ? WS0 : WS1;
   endfunction

   function automatic logic [31:0] baseOf(input int inst);
      return (inst == 0) ? BASE0 : BASE1;
   endfunction

   function automatic void modelWrite(input int inst, input int off, input logic [2:0] size, input logic [31:0] wd);
      int n;
      int start;
      n = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
      start = off - (off % n);
      for (int a = start; a < start + n; a++) begin
         mbytes[inst][a] = wd[8*(a%4) +: 8];
      end
   endfunction

   function automatic logic [31:0] modelRead(input int inst, input int off);
      int s;
      s = off - (off % 4);
      return {mbytes[inst][s+3], mbytes[inst][s+2], mbytes[inst][s+1], mbytes[inst][s]};
   endfunction

   function automatic void pushBeat(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                                    input logic write, input logic [2:0] size, input logic [31:0] wdata);
      beat_t b;
      b.sel = sel; b.trans = trans; b.addr = addr; b.write = write; b.size = size; b.wdata = wdata;
      beats.push_back(b);
   endfunction

   function automatic beat_t randBeat(input logic [31:0] base);
      beat_t b;
      int    kind;
      int    off;
      kind    = int'($urandom_range(0, 9));
      b.write = 1'($urandom());
      b.wdata = $urandom();
      if ($urandom_range(0, 7) == 0) b.size = 3'($urandom_range(3, 7));
      else                           b.size = 3'($urandom_range(0, 2));
      off = int'($urandom_range(0, MEM_BYTES + 15));
      if ($urandom_range(0, 3) != 0 && b.size <= 3'd2) off = off & ~((1 << b.size) - 1);
      b.addr  = base + 32'(off);
      b.sel   = 1'b1;
      b.trans = ($urandom_range(0, 1) != 0) ? T_NONSEQ : T_SEQ;
      if (kind == 0)      b.sel   = 1'b0;
      else if (kind == 1) b.trans = T_IDLE;
      else if (kind == 2) b.trans = T_BUSY;
      return b;
   endfunction

   // Pipelined master: presents the next address phase during the current data phase and
   // advances only when the slave reports ready, checking every cycle against the model.
   task automatic applyStimulus(input int inst);
      beat_t       pend;
      beat_t       dp;
      bit          havePend;
      bit          haveDp;
      bit          dpErr;
      bit          dpInRange;
      logic [31:0] dpOff;
      int          cyc;
      int          budget;
      int          ws;
      logic        rdy;
      logic        expRdy;
      logic        expResp;
      logic [31:0] expData;
      havePend = 0; haveDp = 0; dpErr = 0; dpInRange = 0; dpOff = '0; cyc = 0;
      ws = wsOf(inst);
      budget = (beats.size() + 4) * (ws + 4);
      while (beats.size() > 0 || havePend || haveDp) begin
         if (budget == 0) begin
            checkOutput($sformatf("u%0d_cycle_budget", inst), 32'(beats.size() + int'(havePend) + int'(haveDp)), 32'd0);
            beats.delete();
            break;
         end
         budget--;
         if (!havePend && beats.size() > 0) begin
            pend = beats.pop_front();
            havePend = 1;
            hburst[inst]    = 3'($urandom());
            hprot[inst]     = 4'($urandom());
            hmastlock[inst] = 1'($urandom());
         end
         if (havePend) begin
            hsel[inst] = pend.sel; htrans[inst] = pend.trans; haddr[inst] = pend.addr;
            hwrite[inst] = pend.write; hsize[inst] = pend.size;
         end else begin
            hsel[inst] = 1'b0; htrans[inst] = T_IDLE;
         end
         hwdata[inst] = haveDp ? dp.wdata : $urandom();

         @(negedge HCLK);
         expData = 32'h0;
         if (haveDp && dpErr) begin
            expRdy  = (cyc == 1);
            expResp = 1'b1;
         end else if (haveDp) begin
            expRdy  = (cyc >= ws);
            expResp = 1'b0;
            if (expRdy && dpInRange && !dp.write) expData = modelRead(inst, int'(dpOff));
         end else begin
            expRdy  = 1'b1;
            expResp = 1'b0;
         end
         checkOutput($sformatf("u%0d_hreadyout_c%0d", inst, cyc), 32'(hreadyout[inst]), 32'(expRdy));
         checkOutput($sformatf("u%0d_hresp_c%0d", inst, cyc), 32'(hresp[inst]), 32'(expResp));
         if (!(haveDp && !dpErr && dp.write)) begin
            checkOutput($sformatf("u%0d_hrdata_c%0d", inst, cyc), hrdata[inst], expData);
         end
         if (haveDp && expRdy && !dpErr && !dp.write) lastRead = hrdata[inst];
         rdy = hreadyout[inst];

         @(posedge HCLK);
         #1;
         if (rdy) begin
            if (haveDp && !dpErr && dp.write && dpInRange) modelWrite(inst, int'(dpOff), dp.size, dp.wdata);
            if (haveDp) lastWait = cyc;
            haveDp = 0;
            if (havePend) begin
               if (pend.sel && pend.trans[1]) begin
                  dp        = pend;
                  haveDp    = 1;
                  cyc       = 0;
                  dpOff     = pend.addr - baseOf(inst);
                  dpInRange = (dpOff < 32'(MEM_BYTES));
                  dpErr     = 0;
`ifdef AHB_SLV_ERR_EN
                  dpErr = !dpInRange || (pend.size > 3'd2) || (pend.size == 3'd1 && dpOff[0]) ||
                          (pend.size == 3'd2 && dpOff[1:0] != 2'b00);
`endif
               end
               havePend = 0;
            end
         end else begin
            cyc++;
         end
      end
      hsel[inst]   = 1'b0;
      htrans[inst] = T_IDLE;
   endtask

   initial begin
      testsRun = 0;
      testsFailed = 0;
      lastRead = '0;
      lastWait = 0;
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < MEM_BYTES; a++) mbytes[i][a] = 8'h00;
         hresetn[i] = 1'b0; hsel[i] = 1'b0; haddr[i] = '0; hwrite[i] = 1'b0; hsize[i] = 3'd0;
         hburst[i] = 3'd0; hprot[i] = 4'd0; htrans[i] = T_IDLE; hmastlock[i] = 1'b0; hwdata[i] = '0;
      end
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("u%0d_reset_hreadyout", i), 32'(hreadyout[i]), 32'd1);
         checkOutput($sformatf("u%0d_reset_hresp", i), 32'(hresp[i]), 32'd0);
         checkOutput($sformatf("u%0d_reset_hrdata", i), hrdata[i], 32'd0);
         hresetn[i] = 1'b1;
      end
      @(posedge HCLK);
      #1;

      for (int i = 0; i < 2; i++) begin
         for (int w = 0; w < MEM_WORDS; w++) pushBeat(1'b1, T_NONSEQ, baseOf(i) + 32'(4*w), 1'b1, 3'd2, $urandom());
         applyStimulus(i);
      end

      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h10, 1'b0, 3'd2, 32'h0);
      applyStimulus(0);
      checkOutput("t1_word_readback", lastRead, 32'hDEADBEEF);

      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h10, 1'b1, 3'd2, 32'h0000_0000);
      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h11, 1'b1, 3'd0, 32'h0000_AA00);
      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h10, 1'b0, 3'd2, 32'h0);
      applyStimulus(0);
      checkOutput("t2_byte_lane1", lastRead, 32'h0000_AA00);
      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h12, 1'b1, 3'd1, 32'h1234_0000);
      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h10, 1'b0, 3'd2, 32'h0);
      applyStimulus(0);
      checkOutput("t2_half_upper", lastRead, 32'h1234_AA00);

      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'(MEM_BYTES), 1'b0, 3'd2, 32'h0);
      applyStimulus(0);
`ifdef AHB_SLV_ERR_EN
      checkOutput("t4_oob_read_cycles", 32'(lastWait), 32'd1);
`else
      checkOutput("t4_oob_read_cycles", 32'(lastWait), 32'd0);
      checkOutput("t4_oob_read_data", lastRead, 32'd0);
`endif

      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h00, 1'b1, 3'd2, 32'h0000_0000);
      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h02, 1'b1, 3'd2, 32'h1122_3344);
      pushBeat(1'b1, T_NONSEQ, BASE0 + 32'h00, 1'b0, 3'd2, 32'h0);
      applyStimulus(0);
`ifdef AHB_SLV_ERR_EN
      checkOutput("t5_misaligned_word", lastRead, 32'h0000_0000);
`else
      checkOutput("t5_misaligned_word", lastRead, 32'h1122_3344);
`endif

      pushBeat(1'b1, T_NONSEQ, BASE1 + 32'h10, 1'b0, 3'd2, 32'h0);
      applyStimulus(1);
      checkOutput("t3_wait_cycles", 32'(lastWait), 32'd3);

      for (int i = 0; i < 2; i++) begin
         pushBeat(1'b1, T_NONSEQ, baseOf(i) + 32'h20, 1'b1, 3'd2, 32'hA5A5_0001);
         pushBeat(1'b1, T_BUSY,   baseOf(i) + 32'h24, 1'b1, 3'd2, 32'h0);
         pushBeat(1'b1, T_SEQ,    baseOf(i) + 32'h24, 1'b1, 3'd2, 32'h5A5A_0002);
         pushBeat(1'b0, T_SEQ,    baseOf(i) + 32'h28, 1'b1, 3'd2, 32'hFFFF_FFFF);
         pushBeat(1'b1, T_SEQ,    baseOf(i) + 32'h20, 1'b0, 3'd2, 32'h0);
         pushBeat(1'b1, T_SEQ,    baseOf(i) + 32'h24, 1'b0, 3'd2, 32'h0);
         applyStimulus(i);
         checkOutput($sformatf("u%0d_t6_burst_last", i), lastRead, 32'h5A5A_0002);
      end

      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 150; n++) beats.push_back(randBeat(baseOf(i)));
         applyStimulus(i);
      end

      hsel[1] = 1'b1; htrans[1] = T_NONSEQ; haddr[1] = BASE1 + 32'h20; hwrite[1] = 1'b1; hsize[1] = 3'd2;
      @(posedge HCLK);
      #1;
      hsel[1] = 1'b0; htrans[1] = T_IDLE; hwdata[1] = 32'hCAFE_F00D;
      @(negedge HCLK);
      checkOutput("t6_rst_pre_wait", 32'(hreadyout[1]), 32'd0);
      @(posedge HCLK);
      #2;
      hresetn[1] = 1'b0;
      #1;
      checkOutput("t6_rst_hreadyout", 32'(hreadyout[1]), 32'd1);
      checkOutput("t6_rst_hresp", 32'(hresp[1]), 32'd0);
      checkOutput("t6_rst_hrdata", hrdata[1], 32'd0);
      @(posedge HCLK);
      #1;
      hresetn[1] = 1'b1;
      pushBeat(1'b1, T_NONSEQ, BASE1 + 32'h20, 1'b0, 3'd2, 32'h0);
      applyStimulus(1);
      checkOutput("t6_rst_no_commit", lastRead, modelRead(1, 32'h20));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
